// File: rtl/param_sync_fifo.sv
// Single-clock parameterised FIFO with registered status flags and overflow/underflow pulses.
// Define FIFO_FWFT_EN for first-word-fall-through (zero-latency) reads; default is a registered 1-cycle read.
module param_sync_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int ADD      = 4,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic             rd,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [ADD:0]     count,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [ADD:0] DEPTH_C = (ADD+1)'(DEPTH);
  localparam logic [ADD:0] AF_C    = (ADD+1)'(AF_LEVEL);
  localparam logic [ADD:0] AE_C    = (ADD+1)'(AE_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADD-1:0]   wptr;
  logic [ADD-1:0]   rptr;
  logic             rd_acc;
  logic             wr_acc;
  logic [ADD:0]     count_nxt;

  // A write into a full FIFO is still accepted when a read frees a slot on the same edge.
  always_comb begin
    rd_acc    = rd && !empty;
    wr_acc    = wr && (!full || rd_acc);
    count_nxt = count;
    if (wr_acc && !rd_acc)
      count_nxt = count + 1'b1;
    else if (rd_acc && !wr_acc)
      count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc) wptr <= wptr + 1'b1;
      if (rd_acc) rptr <= rptr + 1'b1;
      count        <= count_nxt;
      full         <= (count_nxt == DEPTH_C);
      empty        <= (count_nxt == '0);
      almost_full  <= (count_nxt >= AF_C);
      almost_empty <= (count_nxt <= AE_C);
      overflow     <= wr && !wr_acc;
      underflow    <= rd && empty;
    end
  end

  // Storage is deliberately not reset; stale words are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc)
      mem[wptr] <= din;
  end

`ifdef FIFO_FWFT_EN
  always_comb begin
    dout = '0;
    if (!empty)
      dout = mem[rptr];
  end
`else
  always_ff @(posedge clk) begin
    if (rst)
      dout <= '0;
    else if (rd_acc)
      dout <= mem[rptr];
  end
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed self-checking bench for param_sync_fifo (default parameters); read latency follows FIFO_FWFT_EN.
module tb_param_sync_fifo;

  logic       clk;
  logic       rst;
  logic       wr;
  logic       rd;
  logic [7:0] din;
  logic [7:0] dout;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  int checks = 0;
  int errors = 0;

  param_sync_fifo #(
    .WIDTH(8), .DEPTH(16), .ADD(4), .AF_LEVEL(14), .AE_LEVEL(2)
  ) dut (
    .clk(clk), .rst(rst), .wr(wr), .rd(rd), .din(din), .dout(dout),
    .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr = 1'b1; rd = 1'b0; din = 8'hEE;
    tick(); tick();
    rst = 1'b0; wr = 1'b0;
    checks++;
    if ({count, empty, full, almost_empty, almost_full, overflow, underflow} !== {5'd0, 6'b101000}) begin
      errors++;
      $display("FAIL reset_flags: got count=%0d e=%b f=%b ae=%b af=%b ov=%b un=%b, need 0 1 0 1 0 0 0",
               count, empty, full, almost_empty, almost_full, overflow, underflow);
    end
    checks++;
    if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h need 00", dout); end
  endtask

  task automatic test_fill();
    for (int unsigned i = 0; i < 16; i++) begin
      din = 8'h11 + 8'(i); wr = 1'b1;
      tick();
      checks++;
      if (count !== 5'(i + 1)) begin errors++; $display("FAIL fill_count[%0d]: got %0d need %0d", i, count, i + 1); end
      checks++;
      if (almost_full !== (i + 1 >= 14) || full !== (i == 15) || empty !== 1'b0 || almost_empty !== (i + 1 <= 2)) begin
        errors++;
        $display("FAIL fill_flags[%0d]: got af=%b f=%b e=%b ae=%b need af=%b f=%b e=0 ae=%b",
                 i, almost_full, full, empty, almost_empty, (i + 1 >= 14), (i == 15), (i + 1 <= 2));
      end
    end
    wr = 1'b0;
  endtask

  task automatic test_overflow();
    din = 8'hAA; wr = 1'b1;
    tick();
    wr = 1'b0;
    checks++;
    if (overflow !== 1'b1 || count !== 5'd16 || full !== 1'b1) begin
      errors++; $display("FAIL overflow_pulse: got ov=%b count=%0d f=%b need 1 16 1", overflow, count, full);
    end
    tick();
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_clear: got %b need 0", overflow); end
    for (int unsigned i = 0; i < 16; i++) begin
`ifdef FIFO_FWFT_EN
      checks++;
      if (dout !== 8'h11 + 8'(i)) begin errors++; $display("FAIL drain_dout[%0d]: got %h need %h", i, dout, 8'h11 + 8'(i)); end
`endif
      rd = 1'b1;
      tick();
`ifndef FIFO_FWFT_EN
      checks++;
      if (dout !== 8'h11 + 8'(i)) begin errors++; $display("FAIL drain_dout[%0d]: got %h need %h", i, dout, 8'h11 + 8'(i)); end
`endif
      checks++;
      if (count !== 5'(15 - i)) begin errors++; $display("FAIL drain_count[%0d]: got %0d need %0d", i, count, 15 - i); end
    end
    rd = 1'b0;
    checks++;
    if (empty !== 1'b1 || almost_empty !== 1'b1 || underflow !== 1'b0) begin
      errors++; $display("FAIL drain_empty: got e=%b ae=%b un=%b need 1 1 0", empty, almost_empty, underflow);
    end
  endtask

  task automatic test_underflow();
    rd = 1'b1;
    tick();
    rd = 1'b0;
    checks++;
    if (underflow !== 1'b1 || count !== 5'd0 || empty !== 1'b1) begin
      errors++; $display("FAIL underflow_pulse: got un=%b count=%0d e=%b need 1 0 1", underflow, count, empty);
    end
`ifndef FIFO_FWFT_EN
    checks++;
    if (dout !== 8'h20) begin errors++; $display("FAIL underflow_dout: got %h need 20", dout); end
`endif
    tick();
    checks++;
    if (underflow !== 1'b0) begin errors++; $display("FAIL underflow_clear: got %b need 0", underflow); end
    // write and read together while empty: write lands, read is rejected
    din = 8'h77; wr = 1'b1; rd = 1'b1;
    tick();
    wr = 1'b0; rd = 1'b0;
    checks++;
    if (underflow !== 1'b1 || count !== 5'd1 || empty !== 1'b0 || overflow !== 1'b0) begin
      errors++; $display("FAIL empty_wr_rd: got un=%b count=%0d e=%b ov=%b need 1 1 0 0", underflow, count, empty, overflow);
    end
`ifdef FIFO_FWFT_EN
    checks++;
    if (dout !== 8'h77) begin errors++; $display("FAIL empty_wr_rd_data: got %h need 77", dout); end
`endif
    rd = 1'b1;
    tick();
    rd = 1'b0;
`ifndef FIFO_FWFT_EN
    checks++;
    if (dout !== 8'h77) begin errors++; $display("FAIL empty_wr_rd_data: got %h need 77", dout); end
`endif
    checks++;
    if (count !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL empty_wr_rd_drain: got count=%0d e=%b need 0 1", count, empty); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] q[$];
    logic [7:0] exp;
    for (int unsigned i = 0; i < 8; i++) begin
      din = 8'h01 + 8'(i); q.push_back(din); wr = 1'b1;
      tick();
    end
    wr = 1'b0;
    checks++;
    if (count !== 5'd8) begin errors++; $display("FAIL b2b_prefill: got %0d need 8", count); end
    for (int unsigned i = 0; i < 8; i++) begin
      din = 8'($urandom); q.push_back(din); wr = 1'b1; rd = 1'b1;
      exp = q.pop_front();
`ifdef FIFO_FWFT_EN
      checks++;
      if (dout !== exp) begin errors++; $display("FAIL b2b_dout[%0d]: got %h need %h", i, dout, exp); end
`endif
      tick();
`ifndef FIFO_FWFT_EN
      checks++;
      if (dout !== exp) begin errors++; $display("FAIL b2b_dout[%0d]: got %h need %h", i, dout, exp); end
`endif
      checks++;
      if (count !== 5'd8 || overflow !== 1'b0 || underflow !== 1'b0) begin
        errors++; $display("FAIL b2b_count[%0d]: got count=%0d ov=%b un=%b need 8 0 0", i, count, overflow, underflow);
      end
    end
    wr = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      exp = q.pop_front();
`ifdef FIFO_FWFT_EN
      checks++;
      if (dout !== exp) begin errors++; $display("FAIL b2b_tail[%0d]: got %h need %h", i, dout, exp); end
`endif
      rd = 1'b1;
      tick();
`ifndef FIFO_FWFT_EN
      checks++;
      if (dout !== exp) begin errors++; $display("FAIL b2b_tail[%0d]: got %h need %h", i, dout, exp); end
`endif
    end
    rd = 1'b0;
    checks++;
    if (empty !== 1'b1) begin errors++; $display("FAIL b2b_empty: got %b need 1", empty); end
  endtask

  task automatic test_full_wr_rd();
    logic [7:0] exp;
    for (int unsigned i = 0; i < 16; i++) begin
      din = 8'h30 + 8'(i); wr = 1'b1;
      tick();
    end
    din = 8'h55; wr = 1'b1; rd = 1'b1;
`ifdef FIFO_FWFT_EN
    checks++;
    if (dout !== 8'h30) begin errors++; $display("FAIL full_wr_rd_dout: got %h need 30", dout); end
`endif
    tick();
    wr = 1'b0; rd = 1'b0;
`ifndef FIFO_FWFT_EN
    checks++;
    if (dout !== 8'h30) begin errors++; $display("FAIL full_wr_rd_dout: got %h need 30", dout); end
`endif
    checks++;
    if (count !== 5'd16 || full !== 1'b1 || overflow !== 1'b0) begin
      errors++; $display("FAIL full_wr_rd: got count=%0d f=%b ov=%b need 16 1 0", count, full, overflow);
    end
    for (int unsigned i = 0; i < 16; i++) begin
      exp = (i == 15) ? 8'h55 : 8'h31 + 8'(i);
`ifdef FIFO_FWFT_EN
      checks++;
      if (dout !== exp) begin errors++; $display("FAIL full_drain[%0d]: got %h need %h", i, dout, exp); end
`endif
      rd = 1'b1;
      tick();
`ifndef FIFO_FWFT_EN
      checks++;
      if (dout !== exp) begin errors++; $display("FAIL full_drain[%0d]: got %h need %h", i, dout, exp); end
`endif
    end
    rd = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int unsigned i = 0; i < 5; i++) begin
      din = 8'hC0 + 8'(i); wr = 1'b1;
      tick();
    end
    checks++;
    if (count !== 5'd5) begin errors++; $display("FAIL mid_prefill: got %0d need 5", count); end
    rst = 1'b1; rd = 1'b1;
    tick();
    rst = 1'b0; wr = 1'b0; rd = 1'b0;
    checks++;
    if (count !== 5'd0 || empty !== 1'b1 || almost_empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0 || dout !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset: got count=%0d e=%b ae=%b ov=%b un=%b dout=%h need 0 1 1 0 0 00",
               count, empty, almost_empty, overflow, underflow, dout);
    end
    din = 8'h3C; wr = 1'b1;
    tick();
    wr = 1'b0;
`ifdef FIFO_FWFT_EN
    checks++;
    if (dout !== 8'h3C) begin errors++; $display("FAIL mid_readback: got %h need 3c", dout); end
`endif
    rd = 1'b1;
    tick();
    rd = 1'b0;
`ifndef FIFO_FWFT_EN
    checks++;
    if (dout !== 8'h3C) begin errors++; $display("FAIL mid_readback: got %h need 3c", dout); end
`endif
    checks++;
    if (count !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL mid_final: got count=%0d e=%b need 0 1", count, empty); end
  endtask

  initial begin
    rst = 1'b1; wr = 1'b0; rd = 1'b0; din = '0;
    test_reset();
    test_fill();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_full_wr_rd();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
